// File: rtl/vx_tex_filter_pipe.sv
// Three-stage texture filter pipeline: captures per-lane texel quads, blends along u, then v.
// Point-sampled entries carry t0 through the same stages so both modes share one latency.
module vx_tex_filter_pipe #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned REQ_INFOW  = 1,
  parameter int unsigned BLEND_FRAC = 8,
  parameter int unsigned PERF_CTR_W = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  input  logic [NUM_REQS-1:0]                req_tmask,
  input  logic                               req_filter,
  input  logic [NUM_REQS*2*BLEND_FRAC-1:0]   req_blends,
  input  logic [NUM_REQS*4*32-1:0]           req_data,
  input  logic [REQ_INFOW-1:0]               req_info,
  output logic                               req_ready,
  output logic                               rsp_valid,
  output logic [NUM_REQS-1:0]                rsp_tmask,
  output logic [NUM_REQS*32-1:0]             rsp_data,
  output logic [REQ_INFOW-1:0]               rsp_info,
  input  logic                               rsp_ready,
  input  logic                               perf_clear,
  output logic [PERF_CTR_W-1:0]              perf_stall_cycles,
  output logic                               busy
);

  localparam int unsigned AccW = 8 + BLEND_FRAC + 1;

  // Per-channel blend; the accumulator is one bit wider than the worst-case sum.
  function automatic logic [7:0] lerp8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [BLEND_FRAC-1:0] f);
    logic [BLEND_FRAC:0] f_inv;
    logic [AccW-1:0]     acc;
    f_inv = {1'b1, {BLEND_FRAC{1'b0}}} - {1'b0, f};
    acc   = AccW'(a) * AccW'(f_inv) + AccW'(b) * AccW'(f);
    return 8'(acc >> BLEND_FRAC);
  endfunction

  function automatic logic [31:0] lerp32(input logic [31:0] a, input logic [31:0] b,
                                         input logic [BLEND_FRAC-1:0] f);
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[8*c +: 8] = lerp8(a[8*c +: 8], b[8*c +: 8], f);
    end
    return r;
  endfunction

  // Stage valid bits
  logic s0_valid_q, s1_valid_q, s2_valid_q;

  // Stage payloads (not reset; qualified by the valid bits)
  logic [NUM_REQS-1:0]              s0_tmask_q, s1_tmask_q, s2_tmask_q;
  logic                             s0_filter_q, s1_filter_q;
  logic [NUM_REQS*2*BLEND_FRAC-1:0] s0_blends_q;
  logic [NUM_REQS*4*32-1:0]         s0_data_q;
  logic [REQ_INFOW-1:0]             s0_info_q, s1_info_q, s2_info_q;
  logic [NUM_REQS*BLEND_FRAC-1:0]   s1_vfrac_q, s1_vfrac_d;
  logic [NUM_REQS*32-1:0]           s1_ul_q, s1_ul_d;
  logic [NUM_REQS*32-1:0]           s1_uh_q, s1_uh_d;
  logic [NUM_REQS*32-1:0]           s2_data_q, s2_data_d;
  logic [PERF_CTR_W-1:0]            perf_q;

  logic s0_ready, s1_ready, s2_ready;
  logic s0_load, s1_load, s2_load;

  // Each stage accepts when empty or when its occupant moves on; bubbles collapse.
  assign s2_ready = ~s2_valid_q | rsp_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign s0_ready = ~s0_valid_q | s1_ready;

  assign s0_load = req_valid & s0_ready;
  assign s1_load = s0_valid_q & s1_ready;
  assign s2_load = s1_valid_q & s2_ready;

  // u-direction blend of both texel rows
  always_comb begin
    s1_ul_d    = '0;
    s1_uh_d    = '0;
    s1_vfrac_d = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      s1_vfrac_d[i*BLEND_FRAC +: BLEND_FRAC] = s0_blends_q[(2*i+1)*BLEND_FRAC +: BLEND_FRAC];
      if (s0_filter_q) begin
        s1_ul_d[i*32 +: 32] = lerp32(s0_data_q[(4*i)*32 +: 32], s0_data_q[(4*i+1)*32 +: 32],
                                     s0_blends_q[(2*i)*BLEND_FRAC +: BLEND_FRAC]);
        s1_uh_d[i*32 +: 32] = lerp32(s0_data_q[(4*i+2)*32 +: 32], s0_data_q[(4*i+3)*32 +: 32],
                                     s0_blends_q[(2*i)*BLEND_FRAC +: BLEND_FRAC]);
      end else begin
        s1_ul_d[i*32 +: 32] = s0_data_q[(4*i)*32 +: 32];
      end
    end
  end

  // v-direction blend, then zero the inactive lanes
  always_comb begin
    s2_data_d = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (s1_tmask_q[i]) begin
        if (s1_filter_q) begin
          s2_data_d[i*32 +: 32] = lerp32(s1_ul_q[i*32 +: 32], s1_uh_q[i*32 +: 32],
                                         s1_vfrac_q[i*BLEND_FRAC +: BLEND_FRAC]);
        end else begin
          s2_data_d[i*32 +: 32] = s1_ul_q[i*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      perf_q     <= '0;
    end else begin
      if (s0_ready) s0_valid_q <= req_valid;
      if (s1_ready) s1_valid_q <= s0_valid_q;
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (perf_clear) begin
        perf_q <= '0;
      end else if (s2_valid_q && !rsp_ready && !(&perf_q)) begin
        perf_q <= perf_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s0_load) begin
      s0_tmask_q  <= req_tmask;
      s0_filter_q <= req_filter;
      s0_blends_q <= req_blends;
      s0_data_q   <= req_data;
      s0_info_q   <= req_info;
    end
    if (s1_load) begin
      s1_tmask_q  <= s0_tmask_q;
      s1_filter_q <= s0_filter_q;
      s1_vfrac_q  <= s1_vfrac_d;
      s1_ul_q     <= s1_ul_d;
      s1_uh_q     <= s1_uh_d;
      s1_info_q   <= s0_info_q;
    end
    if (s2_load) begin
      s2_tmask_q <= s1_tmask_q;
      s2_data_q  <= s2_data_d;
      s2_info_q  <= s1_info_q;
    end
  end

  assign req_ready         = s0_ready;
  assign rsp_valid         = s2_valid_q;
  assign rsp_tmask         = s2_tmask_q;
  assign rsp_data          = s2_data_q;
  assign rsp_info          = s2_info_q;
  assign perf_stall_cycles = perf_q;
  assign busy              = s0_valid_q | s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_vx_tex_filter_pipe.sv
// Bench for vx_tex_filter_pipe: directed steps plus random traffic against a scoreboard
// whose expectations come from the bilinear formula evaluated with plain integer arithmetic.
module tb_vx_tex_filter_pipe;

  localparam int NR = 4;
  localparam int IW = 4;
  localparam int BF = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               req_valid, req_filter, rsp_ready, perf_clear;
  logic [NR-1:0]      req_tmask;
  logic [NR*2*BF-1:0] req_blends;
  logic [NR*128-1:0]  req_data;
  logic [IW-1:0]      req_info;
  logic               req_ready, rsp_valid, busy;
  logic [NR-1:0]      rsp_tmask;
  logic [NR*32-1:0]   rsp_data;
  logic [IW-1:0]      rsp_info;
  logic [31:0]        perf_stall_cycles;

  // Second instance with a narrow counter, permanently back-pressured, for saturation.
  logic               rsp_ready_sat, perf_clear_sat;
  logic               req_ready_sat, rsp_valid_sat, busy_sat;
  logic [NR-1:0]      rsp_tmask_sat;
  logic [NR*32-1:0]   rsp_data_sat;
  logic [IW-1:0]      rsp_info_sat;
  logic [2:0]         perf_sat;

  vx_tex_filter_pipe #(
    .NUM_REQS(NR), .REQ_INFOW(IW), .BLEND_FRAC(BF), .PERF_CTR_W(32)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tmask(req_tmask),
    .req_filter(req_filter), .req_blends(req_blends), .req_data(req_data),
    .req_info(req_info), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_info(rsp_info),
    .rsp_ready(rsp_ready), .perf_clear(perf_clear),
    .perf_stall_cycles(perf_stall_cycles), .busy(busy)
  );

  vx_tex_filter_pipe #(
    .NUM_REQS(NR), .REQ_INFOW(IW), .BLEND_FRAC(BF), .PERF_CTR_W(3)
  ) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tmask(req_tmask),
    .req_filter(req_filter), .req_blends(req_blends), .req_data(req_data),
    .req_info(req_info), .req_ready(req_ready_sat), .rsp_valid(rsp_valid_sat),
    .rsp_tmask(rsp_tmask_sat), .rsp_data(rsp_data_sat), .rsp_info(rsp_info_sat),
    .rsp_ready(rsp_ready_sat), .perf_clear(perf_clear_sat),
    .perf_stall_cycles(perf_sat), .busy(busy_sat)
  );

  typedef struct {
    logic [NR*32-1:0] data;
    logic [NR-1:0]    tmask;
    logic [IW-1:0]    info;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_lerp(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned f);
    logic [31:0] r;
    int unsigned x, y, z;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      x = 32'(a[8*c +: 8]);
      y = 32'(b[8*c +: 8]);
      z = (x * ((1 << BF) - f) + y * f) >> BF;
      r[8*c +: 8] = z[7:0];
    end
    return r;
  endfunction

  function automatic exp_t model(input logic f, input logic [NR-1:0] tm,
                                 input logic [NR*2*BF-1:0] bl, input logic [NR*128-1:0] d,
                                 input logic [IW-1:0] inf);
    exp_t e;
    int unsigned u, v;
    e.data  = '0;
    e.tmask = tm;
    e.info  = inf;
    for (int i = 0; i < NR; i++) begin
      u = 32'(bl[(2*i)*BF +: BF]);
      v = 32'(bl[(2*i+1)*BF +: BF]);
      if (!tm[i])     e.data[i*32 +: 32] = 32'h0;
      else if (!f)    e.data[i*32 +: 32] = d[(4*i)*32 +: 32];
      else            e.data[i*32 +: 32] =
          ref_lerp(ref_lerp(d[(4*i)*32 +: 32], d[(4*i+1)*32 +: 32], u),
                   ref_lerp(d[(4*i+2)*32 +: 32], d[(4*i+3)*32 +: 32], u), v);
    end
    return e;
  endfunction

  // Scoreboard and hold-stability monitor, sampling on the falling edge.
  initial begin
    exp_t             e;
    logic             held_v;
    logic [NR*32-1:0] held_d;
    logic [NR-1:0]    held_t;
    logic [IW-1:0]    held_i;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", 128'(rsp_valid), 128'(1'b1));
          chk("hold_data", rsp_data, held_d);
          chk("hold_tmask", 128'(rsp_tmask), 128'(held_t));
          chk("hold_info", 128'(rsp_info), 128'(held_i));
        end
        held_v = rsp_valid && !rsp_ready;
        held_d = rsp_data;
        held_t = rsp_tmask;
        held_i = rsp_info;
        if (rsp_valid && rsp_ready) begin
          n_assert++;
          assert (q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_rsp: observed response info %0h expected none", rsp_info);
          end
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_tmask", 128'(rsp_tmask), 128'(e.tmask));
            chk("rsp_info", 128'(rsp_info), 128'(e.info));
          end
        end
        if (req_valid && req_ready)
          q.push_back(model(req_filter, req_tmask, req_blends, req_data, req_info));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    req_filter = 1'($urandom);
    req_tmask  = NR'($urandom);
    req_info   = IW'($urandom);
    for (int k = 0; k < NR * 4; k++) req_data[k*32 +: 32] = $urandom;
    for (int k = 0; k < NR * 2; k++) req_blends[k*BF +: BF] = BF'($urandom);
  endtask

  // Holds req_valid until a handshake edge passes; returns the cycles spent waiting.
  task automatic send(output int waited);
    logic acc;
    req_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      step();
      if (acc) break;
      waited++;
      if (waited == 50) break;
    end
    chk("send_accept", 128'(acc), 128'(1'b1));
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; perf_clear = 1'b0;
    rsp_ready_sat = 1'b0; perf_clear_sat = 1'b0;
    rand_req();
    step(); step();
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_perf", 128'(perf_stall_cycles), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
    reset = 1'b0;
    step();

    // Bilinear half-way blend on lane 0
    rand_req();
    req_filter = 1'b1; req_tmask = 4'b0001;
    req_data[127:0] = {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
    req_blends[15:0] = 16'h0080;
    send(w);
    chk("bil_lat_t", 128'(rsp_valid), 128'(1'b0));
    step();
    chk("bil_lat_t1", 128'(rsp_valid), 128'(1'b0));
    step();
    chk("bil_valid_t2", 128'(rsp_valid), 128'(1'b1));
    chk("bil_data", 128'(rsp_data[31:0]), 128'(32'h7F7F_7F7F));
    step(); step();

    // Point sampling with sparse mask
    rand_req();
    req_filter = 1'b0; req_tmask = 4'b1010;
    for (int k = 0; k < NR; k++) req_data[(4*k)*32 +: 32] = 32'h1122_3344;
    send(w);
    step(); step();
    chk("point_data", rsp_data, {32'h1122_3344, 32'h0, 32'h1122_3344, 32'h0});
    chk("point_tmask", 128'(rsp_tmask), 128'(4'b1010));
    step(); step();

    // Eight back-to-back requests
    for (int i = 0; i < 8; i++) begin
      rand_req();
      req_info = IW'(i);
      send(w);
      chk("b2b_wait", 128'(w), 128'(0));
      if (i >= 2) begin
        chk("b2b_valid", 128'(rsp_valid), 128'(1'b1));
        chk("b2b_info", 128'(rsp_info), 128'(i - 2));
      end
    end
    step();
    chk("b2b_info6", 128'(rsp_info), 128'(6));
    step();
    chk("b2b_info7", 128'(rsp_info), 128'(7));
    step();
    chk("b2b_drained", 128'(rsp_valid), 128'(1'b0));

    // Five-cycle output stall with a four-deep stream
    perf_clear = 1'b1; step(); perf_clear = 1'b0;
    chk("clr_perf", 128'(perf_stall_cycles), 128'(0));
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      send(w);
    end
    chk("stall_perf0", 128'(perf_stall_cycles), 128'(0));
    rand_req();
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_req_ready", 128'(req_ready), 128'(1'b0));
      step();
    end
    chk("stall_perf5", 128'(perf_stall_cycles), 128'(5));
    rsp_ready = 1'b1;
    send(w);
    for (int k = 0; k < 6; k++) step();
    chk("stall_drain_q", 128'(q.size()), 128'(0));
    chk("stall_drain_busy", 128'(busy), 128'(1'b0));
    chk("stall_perf_kept", 128'(perf_stall_cycles), 128'(5));

    // Bubble collapse behind a stalled output, plus clear during stall
    rsp_ready = 1'b0;
    rand_req(); send(w);
    step(); step();
    chk("bubble_req_ready", 128'(req_ready), 128'(1'b1));
    rand_req(); send(w);
    chk("bubble_acc1", 128'(w), 128'(0));
    rand_req(); send(w);
    chk("bubble_acc2", 128'(w), 128'(0));
    chk("bubble_full", 128'(req_ready), 128'(1'b0));
    perf_clear = 1'b1; step(); perf_clear = 1'b0;
    chk("stall_clear", 128'(perf_stall_cycles), 128'(0));
    step();
    chk("stall_after_clear", 128'(perf_stall_cycles), 128'(1));
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("bubble_drain_q", 128'(q.size()), 128'(0));

    // Reset with three entries in flight
    for (int i = 0; i < 3; i++) begin
      rand_req();
      send(w);
    end
    chk("pre_rst_busy", 128'(busy), 128'(1'b1));
    reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("mid_rst_busy", 128'(busy), 128'(1'b0));
    chk("mid_rst_req_ready", 128'(req_ready), 128'(1'b1));
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    end

    // Random traffic with random back-pressure
    for (int c = 0; c < 300; c++) begin
      rand_req();
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 3) != 0;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (q.size() == 0 && !busy) break;
      step();
    end
    chk("rand_drain_q", 128'(q.size()), 128'(0));
    chk("rand_drain_busy", 128'(busy), 128'(1'b0));

    // Narrow counter saturates and then clears
    chk("sat_perf", 128'(perf_sat), 128'(3'h7));
    perf_clear_sat = 1'b1; step(); perf_clear_sat = 1'b0;
    chk("sat_clear", 128'(perf_sat), 128'(0));
    step();
    chk("sat_recount", 128'(perf_sat), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
